exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
- Single-cycle MIPS execute/memory slice: main control decoder, 32-bit ALU with internal B-operand select, and word-addressed data memory.
- Sits between the register file/immediate extender and the write-back mux/next-PC logic of the single-cycle core.
- Decodes op/funct into datapath controls, computes the ALU result and zero flag, and performs lw/sw accesses.

Parameters:
- DM_DEPTH, 3072, number of 32-bit data-memory words (max 4096).
- RESET_PC, 32'h00003000, informational; not used by logic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears data memory.
- pc  in  32  PC of the current instruction (write trace only).
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rs_data  in  32  GRF RD1; ALU operand A.
- rt_data  in  32  GRF RD2; ALU register operand B and store data.
- ext_imm  in  32  extended immediate from the extender.
- reg_dst  out  2  00=rt, 01=rd, 10=$31.
- mem_to_reg  out  2  00=ALU result, 01=DM data, 10=PC+4.
- reg_write  out  1  GRF write enable.
- npc_sel  out  2  00=PC+4, 01=beq, 10=jal, 11=jr.
- ext_op  out  2  00=zero-extend, 01=sign-extend, 10=imm16<<16.
- alu_result  out  32  ALU output.
- is_zero  out  1  1 when alu_result == 0.
- dm_rdata  out  32  data-memory read word.

Behaviour:
- Decode is combinational. Internal controls are alu_src (B = ext_imm when 1, else rt_data), mem_write, and alu_op[3:0].
- alu_op codes: 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 PASS_B, 0101 SLT (signed, result 0/1).
- ADD/SUB wrap modulo 2^32 with no overflow trap.
- Decode table:
  - addu: op 000000, funct 100001. rd, ALU, write, ADD.
  - subu: op 000000, funct 100011. rd, ALU, write, SUB.
  - jr: op 000000, funct 001000. npc 11, no write.
  - ori: op 001101. rt, imm, zero-ext, OR, write.
  - lui: op 001111. rt, imm, ext 10, PASS_B, write.
  - lw: op 100011. rt, imm, sign-ext, ADD, mem_to_reg 01, write.
  - sw: op 101011. imm, sign-ext, ADD, mem_write=1, no reg write.
  - beq: op 000100. SUB on rt_data, npc 01, no write.
  - jal: op 000011. reg_dst 10, mem_to_reg 10, npc 10, write.
- Any other op/funct, including all-zero nop: every output control is 0, mem_write=0, alu_op=ADD, alu_src=0.
- Data memory:
  - Word index is alu_result[13:2]; address bits [1:0] are ignored.
  - Read is asynchronous: dm_rdata = mem[index], or 0 when index >= DM_DEPTH.
  - Write happens on the rising clk edge when mem_write=1 and reset=0: mem[index] <= rt_data. Writes with index >= DM_DEPTH are dropped.
  - Reset: every word becomes 0 at the rising edge. Reset has priority over a simultaneous write.
  - Initial content is 0.
- Read-during-write in the same cycle returns the old word; the new value is visible after the edge.
- No pipeline state: all outputs other than memory contents are a combinational function of the inputs.

Optional Feature:
- DM_WRITE_TRACE_EN defined: every committed DM write prints `"@%h: *%h <= %h"` with pc, {18'b0, index, 2'b00}, rt_data. It is simulation-only.
- Not defined: no display and no trace logic. Memory behaviour is identical in both cases.

Test Plan:
- ori, rs_data=0, ext_imm=32'h0000_1234 -> alu_result 32'h1234, reg_dst 00, ext_op 00, reg_write 1.
- addu 32'hFFFF_FFFF+1 -> alu_result 0, is_zero 1. subu 5-7 -> 32'hFFFF_FFFE.
- sw with rs_data=0, ext_imm=8, rt_data=32'hDEAD_BEEF, then clock -> trace "@00003000: *00000008 <= deadbeef". lw at the same address -> dm_rdata 32'hDEADBEEF, mem_to_reg 01.
- beq, rs_data=rt_data=32'h55 -> is_zero 1, npc_sel 01, reg_write 0. jal -> reg_dst 10, mem_to_reg 10, npc_sel 10. jr -> npc_sel 11.
- sw asserted in the same cycle as reset=1, then lw at that address -> 0. Write to index >= DM_DEPTH -> read returns 0 and no other word changes.
- lui, ext_imm=32'hABCD_0000 -> alu_result 32'hABCD0000. Undefined op 111111 -> all controls 0 and no memory write.

Source files
------------

// File: rtl/exec_mem_if.sv
// exec_mem_if: signal bundle between the single-cycle core and its execute/memory slice.
//   master : core side; drives pc, op, funct, rs_data, rt_data and ext_imm, and receives
//            the decoded controls, the ALU result, the zero flag and the data-memory read word.
//   slave  : exec_mem_unit side; the mirror image of master.
interface exec_mem_if;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ext_imm;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [1:0]  npc_sel;
    logic [1:0]  ext_op;
    logic [31:0] alu_result;
    logic        is_zero;
    logic [31:0] dm_rdata;

    modport master (
        output pc, op, funct, rs_data, rt_data, ext_imm,
        input  reg_dst, mem_to_reg, reg_write, npc_sel, ext_op, alu_result, is_zero, dm_rdata
    );

    modport slave (
        input  pc, op, funct, rs_data, rt_data, ext_imm,
        output reg_dst, mem_to_reg, reg_write, npc_sel, ext_op, alu_result, is_zero, dm_rdata
    );
endinterface

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: single-cycle MIPS execute/memory slice.
//   Decodes op/funct into datapath controls, runs the 32-bit ALU (B operand chosen
//   internally between rt_data and ext_imm) and accesses a word-addressed data memory.
// Ports:
//   clk   - system clock, rising edge.
//   reset - synchronous, active-high; clears every data-memory word.
//   bus   - exec_mem_if.slave: pc/op/funct/rs_data/rt_data/ext_imm in; reg_dst, mem_to_reg,
//           reg_write, npc_sel, ext_op, alu_result, is_zero, dm_rdata out.
// Build option: define DM_WRITE_TRACE_EN to print every committed data-memory write
//   (simulation only); memory behaviour is identical either way.
module exec_mem_unit #(
    parameter int unsigned DM_DEPTH = 3072,
    parameter logic [31:0] RESET_PC = 32'h0000_3000  // informational only
) (
    input logic    clk,
    input logic    reset,
    exec_mem_if.slave bus
);

    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSub   = 4'b0001,
        AluOr    = 4'b0010,
        AluAnd   = 4'b0011,
        AluPassB = 4'b0100,
        AluSlt   = 4'b0101
    } alu_op_e;

    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [1:0]  npc_sel;
    logic [1:0]  ext_op;
    logic        alu_src;
    logic        mem_write;
    alu_op_e     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    // ---------------- main control decoder ----------------
    always_comb begin
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        npc_sel    = 2'b00;
        ext_op     = 2'b00;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        alu_op     = AluAdd;
        unique case (bus.op)
            6'b000000: begin
                unique case (bus.funct)
                    6'b100001: begin  // addu
                        reg_dst   = 2'b01;
                        reg_write = 1'b1;
                    end
                    6'b100011: begin  // subu
                        reg_dst   = 2'b01;
                        reg_write = 1'b1;
                        alu_op    = AluSub;
                    end
                    6'b001000: npc_sel = 2'b11;  // jr
                    default: ;
                endcase
            end
            6'b001101: begin  // ori
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = AluOr;
            end
            6'b001111: begin  // lui
                alu_src   = 1'b1;
                ext_op    = 2'b10;
                reg_write = 1'b1;
                alu_op    = AluPassB;
            end
            6'b100011: begin  // lw
                alu_src    = 1'b1;
                ext_op     = 2'b01;
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            6'b101011: begin  // sw
                alu_src   = 1'b1;
                ext_op    = 2'b01;
                mem_write = 1'b1;
            end
            6'b000100: begin  // beq: compare via subtraction, zero flag drives the branch
                npc_sel = 2'b01;
                alu_op  = AluSub;
            end
            6'b000011: begin  // jal
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                npc_sel    = 2'b10;
                reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- ALU ----------------
    assign alu_b = alu_src ? bus.ext_imm : bus.rt_data;

    always_comb begin
        alu_result = 32'h0;
        unique case (alu_op)
            AluAdd:   alu_result = bus.rs_data + alu_b;
            AluSub:   alu_result = bus.rs_data - alu_b;
            AluOr:    alu_result = bus.rs_data | alu_b;
            AluAnd:   alu_result = bus.rs_data & alu_b;
            AluPassB: alu_result = alu_b;
            AluSlt:   alu_result = {31'h0, $signed(bus.rs_data) < $signed(alu_b)};
            default:  alu_result = 32'h0;
        endcase
    end

    // ---------------- data memory ----------------
    logic [31:0] mem [DM_DEPTH];
    logic [11:0] dm_index;
    logic        dm_in_range;

    assign dm_index    = alu_result[13:2];
    assign dm_in_range = 32'(dm_index) < DM_DEPTH;

    // Reset wins over a simultaneous store; out-of-range stores are silently dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_write && dm_in_range) begin
            mem[dm_index] <= bus.rt_data;
        end
    end

`ifdef DM_WRITE_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && mem_write && dm_in_range) begin
            $display("@%h: *%h <= %h", bus.pc, {18'b0, dm_index, 2'b00}, bus.rt_data);
        end
    end
`endif

    // pc only feeds the optional write trace.
    logic unused_pc;
    assign unused_pc = ^{bus.pc, RESET_PC};

    // ---------------- outputs ----------------
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.npc_sel    = npc_sel;
    assign bus.ext_op     = ext_op;
    assign bus.alu_result = alu_result;
    assign bus.is_zero    = (alu_result == 32'h0);
    assign bus.dm_rdata   = dm_in_range ? mem[dm_index] : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: directed bench for exec_mem_unit. Expected values are pushed to a
// scoreboard queue as each instruction is driven and popped/compared once outputs settle.
module tb_exec_mem_unit;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_JR   = 6'b001000;

    logic clk;
    logic reset;
    exec_mem_if bus ();

    exec_mem_unit #(
        .DM_DEPTH (3072),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] observe(string tag);
        case (tag)
            "alu":  return bus.alu_result;
            "zero": return {31'h0, bus.is_zero};
            "dst":  return {30'h0, bus.reg_dst};
            "m2r":  return {30'h0, bus.mem_to_reg};
            "rw":   return {31'h0, bus.reg_write};
            "npc":  return {30'h0, bus.npc_sel};
            "ext":  return {30'h0, bus.ext_op};
            "rd":   return bus.dm_rdata;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(string tag, logic [31:0] exp);
        sb_q.push_back('{tag: tag, exp: exp});
    endtask

    task automatic push_ctrl(logic [1:0] dst, logic [1:0] m2r, logic rw, logic [1:0] npc,
                             logic [1:0] ext);
        push("dst", {30'h0, dst});
        push("m2r", {30'h0, m2r});
        push("rw",  {31'h0, rw});
        push("npc", {30'h0, npc});
        push("ext", {30'h0, ext});
    endtask

    // Pop every pending expectation and compare with the settled DUT outputs.
    task automatic drain(string step);
        sb_item_t    it;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            got = observe(it.tag);
            n_checks++;
            assert (got === it.exp) else begin
                n_fail++;
                $error("FAIL %s.%s observed=%h expected=%h", step, it.tag, got, it.exp);
            end
        end
    endtask

    task automatic drive(logic [5:0] op, logic [5:0] funct, logic [31:0] rs, logic [31:0] rt,
                         logic [31:0] imm);
        @(negedge clk);
        bus.op      = op;
        bus.funct   = funct;
        bus.rs_data = rs;
        bus.rt_data = rt;
        bus.ext_imm = imm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pc      = 32'h0000_3000;
        bus.op      = 6'h0;
        bus.funct   = 6'h0;
        bus.rs_data = 32'h0;
        bus.rt_data = 32'h0;
        bus.ext_imm = 32'h0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state: nop decodes to all-zero controls, memory reads zero.
        drive(6'h0, 6'h0, 32'h0, 32'h0, 32'h0);
        push_ctrl(2'b00, 2'b00, 1'b0, 2'b00, 2'b00);
        push("alu", 32'h0); push("zero", 32'h1); push("rd", 32'h0);
        drain("reset_nop");

        drive(OP_ORI, 6'h0, 32'h0, 32'h0, 32'h0000_1234);
        push_ctrl(2'b00, 2'b00, 1'b1, 2'b00, 2'b00);
        push("alu", 32'h1234); push("zero", 32'h0);
        drain("ori");

        drive(OP_R, F_ADDU, 32'hFFFF_FFFF, 32'h1, 32'h0);
        push_ctrl(2'b01, 2'b00, 1'b1, 2'b00, 2'b00);
        push("alu", 32'h0); push("zero", 32'h1);
        drain("addu_wrap");

        drive(OP_R, F_SUBU, 32'h5, 32'h7, 32'h0);
        push_ctrl(2'b01, 2'b00, 1'b1, 2'b00, 2'b00);
        push("alu", 32'hFFFF_FFFE); push("zero", 32'h0);
        drain("subu");

        // Store: before the edge the word is still 0.
        drive(OP_SW, 6'h0, 32'h0, 32'hDEAD_BEEF, 32'h8);
        push_ctrl(2'b00, 2'b00, 1'b0, 2'b00, 2'b01);
        push("alu", 32'h8); push("rd", 32'h0);
        drain("sw_pre");
        tick();

        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h8);
        push_ctrl(2'b00, 2'b01, 1'b1, 2'b00, 2'b01);
        push("rd", 32'hDEAD_BEEF);
        drain("lw");

        // Read during write returns the old word until the edge.
        drive(OP_SW, 6'h0, 32'h0, 32'h1234_5678, 32'h8);
        push("rd", 32'hDEAD_BEEF);
        drain("rdw_old");
        tick();
        push("rd", 32'h1234_5678);
        drain("rdw_new");

        drive(OP_BEQ, 6'h0, 32'h55, 32'h55, 32'h0);
        push_ctrl(2'b00, 2'b00, 1'b0, 2'b01, 2'b00);
        push("zero", 32'h1);
        drain("beq_taken");

        // ext_imm differs to catch a wrong B-operand select on beq.
        drive(OP_BEQ, 6'h0, 32'h55, 32'h56, 32'h55);
        push("alu", 32'hFFFF_FFFF); push("zero", 32'h0);
        drain("beq_not");

        drive(OP_JAL, 6'h0, 32'h0, 32'h0, 32'h0);
        push_ctrl(2'b10, 2'b10, 1'b1, 2'b10, 2'b00);
        drain("jal");

        drive(OP_R, F_JR, 32'h3000, 32'h0, 32'h0);
        push_ctrl(2'b00, 2'b00, 1'b0, 2'b11, 2'b00);
        drain("jr");

        // Store coinciding with reset: reset wins and clears address 8 too.
        drive(OP_SW, 6'h0, 32'h0, 32'hAAAA_AAAA, 32'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h10);
        push("rd", 32'h0);
        drain("reset_vs_sw");
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h8);
        push("rd", 32'h0);
        drain("reset_clears");

        // Out-of-range store (index 3072) is dropped and disturbs nothing.
        drive(OP_SW, 6'h0, 32'h0, 32'h0000_0001, 32'h20);
        tick();
        drive(OP_SW, 6'h0, 32'h0, 32'h0000_0077, 32'h3000);
        tick();
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h3000);
        push("rd", 32'h0);
        drain("oob_read");
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h20);
        push("rd", 32'h1);
        drain("oob_neighbor");
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h0);
        push("rd", 32'h0);
        drain("oob_word0");
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h23);
        push("rd", 32'h1);
        drain("byte_bits_ignored");

        drive(OP_LUI, 6'h0, 32'h1111_1111, 32'h0, 32'hABCD_0000);
        push_ctrl(2'b00, 2'b00, 1'b1, 2'b00, 2'b10);
        push("alu", 32'hABCD_0000);
        drain("lui");

        // Undefined op: controls zero, ADD on rt_data, no store to index 8.
        drive(6'b111111, 6'h0, 32'h1C, 32'h4, 32'h0);
        push_ctrl(2'b00, 2'b00, 1'b0, 2'b00, 2'b00);
        push("alu", 32'h20); push("rd", 32'h1);
        drain("undef");
        tick();
        drive(OP_LW, 6'h0, 32'h0, 32'h0, 32'h20);
        push("rd", 32'h1);
        drain("undef_nowrite");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
